nmr_scan_scheduler: RTL

- Multi-scan sequencer for the NMR pulse-sequence bit streamer.
- Repeats the stored pulse sequence NSCAN times, inserting a programmable repetition delay (TR) between scans.
- Steps a phase-cycle index each scan, clears the streamer before every scan, and emits an acquisition trigger.
- Sits between the host control registers (GO/ABORT/config) and the streamer's START/DONE/RST pins.

---
 rtl/nmr_scan_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/nmr_scan_scheduler.sv
// Multi-scan sequencer: replays the streamer's stored sequence NSCAN times with
// a repetition delay, phase-cycle stepping, acquisition trigger and watchdog.
module nmr_scan_scheduler #(
  parameter int SCAN_WIDTH = 16,
  parameter int TR_WIDTH   = 32,
  parameter int PH_WIDTH   = 2,
  parameter int WDOG_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  GO,
  input  logic                  ABORT,
  input  logic [SCAN_WIDTH-1:0] NSCAN,
  input  logic [TR_WIDTH-1:0]   TR_DLY,
  input  logic [WDOG_WIDTH-1:0] WDOG_LIM,
  output logic                  SEQ_START,
  output logic                  SEQ_CLR,
  input  logic                  SEQ_DONE,
  output logic                  ACQ_TRIG,
  output logic [PH_WIDTH-1:0]   PH_CYC,
  output logic [SCAN_WIDTH-1:0] SCAN_CNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  ABORTED
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ARM,
    S_RUN,
    S_TRW,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic                  go_q;
  logic [SCAN_WIDTH-1:0] nscan_q;
  logic [TR_WIDTH-1:0]   tr_q;
  logic [WDOG_WIDTH-1:0] wdog_lim_q;
  logic [WDOG_WIDTH-1:0] wdog_cnt;
  logic [TR_WIDTH-1:0]   tr_cnt;

  logic go_edge;
  logic start_run;
  logic abort_take;
  logic run_done;
  logic wdog_to;
  logic tr_exp;
  logic last_scan;

  // Next-state decode; abort overrides every other exit from a busy state.
  always_comb begin
    state_nxt  = state;
    go_edge    = GO & ~go_q;
    start_run  = (state == S_IDLE) && go_edge;
    abort_take = ABORT && (state != S_IDLE);
    run_done   = (state == S_RUN) && SEQ_DONE;
    wdog_to    = (state == S_RUN) && !SEQ_DONE && (wdog_lim_q != '0) &&
                 (wdog_cnt == WDOG_WIDTH'(1));
    tr_exp     = (state == S_TRW) && (tr_cnt == '0);
    last_scan  = ((SCAN_CNT + SCAN_WIDTH'(1)) == nscan_q);

    unique case (state)
      S_IDLE: if (start_run && (NSCAN != '0)) state_nxt = S_CLR;
      S_CLR:  state_nxt = S_ARM;
      S_ARM:  state_nxt = S_RUN;
      S_RUN: begin
        if (run_done)     state_nxt = last_scan ? S_FIN : S_TRW;
        else if (wdog_to) state_nxt = S_IDLE;
      end
      S_TRW:  if (tr_exp) state_nxt = S_CLR;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (abort_take) state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Streamer-facing outputs are decoded from the next state so they line up
  // with the state they belong to; the clear also fires on abort/timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      go_q      <= 1'b0;
      SEQ_CLR   <= 1'b0;
      SEQ_START <= 1'b0;
      ACQ_TRIG  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      go_q      <= GO;
      SEQ_CLR   <= (state_nxt == S_CLR) || abort_take || wdog_to;
      SEQ_START <= (state_nxt == S_ARM) || (state_nxt == S_RUN);
      ACQ_TRIG  <= (state_nxt == S_ARM);
      BUSY      <= (state_nxt != S_IDLE);
    end
  end

  // Run status: cleared on a new run, sticky until then.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SCAN_CNT <= '0;
      PH_CYC   <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      ABORTED  <= 1'b0;
    end else if (start_run) begin
      SCAN_CNT <= '0;
      PH_CYC   <= '0;
      DONE     <= (NSCAN == '0);
      ERR      <= 1'b0;
      ABORTED  <= 1'b0;
    end else if (abort_take) begin
      ABORTED <= 1'b1;
      DONE    <= 1'b1;
    end else begin
      if (run_done) SCAN_CNT <= SCAN_CNT + SCAN_WIDTH'(1);
      if (tr_exp)   PH_CYC   <= PH_CYC + PH_WIDTH'(1);
      if (wdog_to) begin
        ERR  <= 1'b1;
        DONE <= 1'b1;
      end
      if (state == S_FIN) DONE <= 1'b1;
    end
  end

  // Run configuration and the watchdog / repetition-delay counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nscan_q    <= '0;
      tr_q       <= '0;
      wdog_lim_q <= '0;
      wdog_cnt   <= '0;
      tr_cnt     <= '0;
    end else begin
      if (start_run) begin
        nscan_q    <= NSCAN;
        tr_q       <= TR_DLY;
        wdog_lim_q <= WDOG_LIM;
      end

      if (state == S_ARM)
        wdog_cnt <= wdog_lim_q;
      else if ((state == S_RUN) && (wdog_cnt != '0))
        wdog_cnt <= wdog_cnt - WDOG_WIDTH'(1);

      if (run_done)
        tr_cnt <= tr_q;
      else if ((state == S_TRW) && (tr_cnt != '0))
        tr_cnt <= tr_cnt - TR_WIDTH'(1);
    end
  end

endmodule
